// File: rtl/wdt_pkg.sv
// Shared types and sizing helpers for the watchdog kick supervisor.
package wdt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      WARN  = 2'd2,
      FATAL = 2'd3
   } wdt_state_e;

   // Width of the escalation counter: must hold WARN_LIMIT itself.
   function automatic int warn_cnt_width(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/wdt_kick_ctrl_kick_tracker.sv
// Per-period kick accumulator: records which enabled clients kicked and
// flags when the current round is complete.
module kick_tracker #(
   parameter int N = 4
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic         i_en,
   input  logic         i_clr,
   input  logic [N-1:0] i_mask,
   input  logic [N-1:0] i_kick,
   output logic         o_round_complete,
   output logic [N-1:0] o_missing
);

   logic [N-1:0] r_kicked;
   logic [N-1:0] w_kick_m;

   assign w_kick_m         = i_kick & i_mask;
   // A kick arriving in the completing cycle closes the current round.
   assign o_round_complete = ((r_kicked | w_kick_m) == i_mask);
   assign o_missing        = i_mask & ~r_kicked;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_kicked <= '0;
      end else if (i_clr) begin
         r_kicked <= '0;
      end else if (i_en) begin
         r_kicked <= r_kicked | w_kick_m;
      end
   end

endmodule

// File: rtl/wdt_kick_ctrl.sv
// Watchdog supervisor: arms a shared timer, restarts it once every enabled
// client has kicked, and escalates warning -> fatal reset on expiries.
module wdt_kick_ctrl
   import wdt_pkg::*;
#(
   parameter int N_CLIENTS  = 4,
   parameter int WD_CNT_W   = 16,
   parameter int WARN_LIMIT = 2
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic [WD_CNT_W-1:0]  i_timeout,
   input  logic [N_CLIENTS-1:0] i_client_mask,
   input  logic [N_CLIENTS-1:0] i_kick,
   input  logic                 i_wd_irq,
   output logic                 o_wd_en,
   output logic                 o_wd_clear,
   output logic [WD_CNT_W-1:0]  o_wd_val,
   output logic                 o_warn_irq,
   output logic                 o_reset_req,
   output logic [N_CLIENTS-1:0] o_missing,
   output logic [1:0]           o_state
);

   localparam int                  WARN_CNT_W = warn_cnt_width(WARN_LIMIT);
   localparam logic [WARN_CNT_W:0] LIMIT_EXT  = WARN_LIMIT[WARN_CNT_W:0];

   wdt_state_e             r_state;
   logic [N_CLIENTS-1:0]   r_mask;
   logic [N_CLIENTS-1:0]   r_missing;
   logic [WD_CNT_W-1:0]    r_wd_val;
   logic [WARN_CNT_W-1:0]  r_warn_cnt;
   logic                   r_wd_en;
   logic                   r_wd_clear;
   logic                   r_warn_irq;
   logic                   r_reset_req;

   logic                   w_active;
   logic                   w_start_ok;
   logic                   w_irq_eval;
   logic                   w_round_complete;
   logic                   w_trk_clr;
   logic [N_CLIENTS-1:0]   w_missing;
   logic [WARN_CNT_W:0]    w_warn_sum;
   logic                   w_escalate;

   function automatic logic [WARN_CNT_W-1:0] sat_inc(input logic [WARN_CNT_W-1:0] v);
      logic [WARN_CNT_W:0] s;
      s = {1'b0, v} + {{WARN_CNT_W{1'b0}}, 1'b1};
      if (s > LIMIT_EXT) sat_inc = LIMIT_EXT[WARN_CNT_W-1:0];
      else               sat_inc = s[WARN_CNT_W-1:0];
   endfunction

   assign w_active   = (r_state == RUN) || (r_state == WARN);
   assign w_start_ok = i_start && (i_client_mask != '0) && (i_timeout != '0);
   // The timer's irq is still high during our clear cycle; ignore it then.
   assign w_irq_eval = w_active && i_wd_irq && !r_wd_clear;
   assign w_trk_clr  = i_stop || !w_active || w_round_complete || w_irq_eval;
   assign w_warn_sum = {1'b0, r_warn_cnt} + {{WARN_CNT_W{1'b0}}, 1'b1};
   assign w_escalate = (w_warn_sum >= LIMIT_EXT);

   kick_tracker #(
      .N (N_CLIENTS)
   ) u_kick_tracker (
      .i_clk            (i_clk),
      .i_reset_n        (i_reset_n),
      .i_en             (w_active),
      .i_clr            (w_trk_clr),
      .i_mask           (r_mask),
      .i_kick           (i_kick),
      .o_round_complete (w_round_complete),
      .o_missing        (w_missing)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= IDLE;
         r_mask      <= '0;
         r_wd_val    <= '0;
         r_warn_cnt  <= '0;
         r_wd_en     <= 1'b0;
         r_wd_clear  <= 1'b0;
         r_warn_irq  <= 1'b0;
         r_reset_req <= 1'b0;
         r_missing   <= '0;
      end else begin
         r_wd_clear <= 1'b0;
         if (i_stop) begin
            r_state     <= IDLE;
            r_wd_en     <= 1'b0;
            r_warn_irq  <= 1'b0;
            r_reset_req <= 1'b0;
            r_missing   <= '0;
            r_warn_cnt  <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_start_ok) begin
                     r_mask   <= i_client_mask;
                     r_wd_val <= i_timeout;
                     r_wd_en  <= 1'b1;
                     r_state  <= RUN;
                  end
               end
               RUN, WARN: begin
                  if (w_round_complete) begin
                     r_wd_clear <= 1'b1;
                     r_warn_cnt <= '0;
                     r_warn_irq <= 1'b0;
                     r_state    <= RUN;
                  end else if (w_irq_eval) begin
                     r_missing  <= w_missing;
                     r_warn_cnt <= sat_inc(r_warn_cnt);
                     if (w_escalate) begin
                        r_state     <= FATAL;
                        r_reset_req <= 1'b1;
                        r_wd_en     <= 1'b0;
                     end else begin
                        r_warn_irq <= 1'b1;
                        r_wd_clear <= 1'b1;
                        r_state    <= WARN;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_wd_en     = r_wd_en;
   assign o_wd_clear  = r_wd_clear;
   assign o_wd_val    = r_wd_val;
   assign o_warn_irq  = r_warn_irq;
   assign o_reset_req = r_reset_req;
   assign o_missing   = r_missing;
   assign o_state     = r_state;

endmodule

// File: doc/wdt_kick_ctrl.md
Name: wdt_kick_ctrl

Overview:
Supervisor that sequences one shared watchdog timer on behalf of N software/hardware clients in the CRC engine. It arms the timer and collects periodic "kicks" from every enabled client. It restarts the timer only when all enabled clients have kicked in the current period. On timer expiry it escalates: warning interrupt first, then a sticky reset request after WARN_LIMIT consecutive expiries.

Parameters:
N_CLIENTS, 4, number of kicking clients (1..16)
WD_CNT_W, 16, timer load-value width
WARN_LIMIT, 2, consecutive expiries (without a completed kick round) that trigger FATAL; min 1

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous, active-low reset
i_start  in  1  pulse; arm supervisor (honoured in IDLE only)
i_stop  in  1  pulse; disarm from any state
i_timeout  in  WD_CNT_W  timer load value, latched on accepted i_start
i_client_mask  in  N_CLIENTS  enabled clients, latched on accepted i_start
i_kick  in  N_CLIENTS  per-client kick pulses
i_wd_irq  in  1  expiry flag from timer (sticky until timer clear)
o_wd_en  out  1  timer enable; rising edge loads o_wd_val
o_wd_clear  out  1  one-cycle timer reload and irq clear
o_wd_val  out  WD_CNT_W  latched timeout
o_warn_irq  out  1  warning interrupt, level
o_reset_req  out  1  fatal reset request, sticky
o_missing  out  N_CLIENTS  clients that had not kicked at the last expiry
o_state  out  2  0 IDLE, 1 RUN, 2 WARN, 3 FATAL

Behaviour:
- Reset: state IDLE; every output 0; internal mask, kicked vector and warn count 0.
- All outputs are registered.
- IDLE:
  - i_start with i_client_mask!=0 and i_timeout!=0 latches mask and timeout, then enters RUN.
  - o_wd_en=1 from the next cycle.
  - Any other i_start is ignored.
- RUN/WARN kick tracking:
  - kicked |= i_kick & mask every cycle.
  - Round complete when (kicked | (i_kick & mask)) == mask.
  - On round complete: o_wd_clear=1 next cycle, kicked<=0, warn_cnt<=0, o_warn_irq<=0, state<=RUN.
  - Kicks in the completing cycle count toward the finished round only.
  - Kicks from unmasked clients are ignored.
- Expiry:
  - i_wd_irq is evaluated only when o_wd_clear==0; this masks the stale irq during the clear cycle.
  - On an evaluated irq with no round complete: o_missing<=mask&~kicked, warn_cnt++, kicked<=0, o_wd_clear=1 next cycle.
  - If warn_cnt+1 < WARN_LIMIT: o_warn_irq<=1, state WARN.
  - Otherwise: state FATAL, o_reset_req<=1, o_wd_en<=0, no clear pulse.
- Same cycle round complete and irq: round complete wins; no warning, warn_cnt reset.
- FATAL:
  - Timer disabled; kicks ignored; o_reset_req, o_warn_irq and o_missing hold.
  - Leaves only via i_stop or reset.
- i_stop has highest priority in every state:
  - Next cycle: IDLE, o_wd_en=0, o_wd_clear=0, o_warn_irq=0, o_reset_req=0, o_missing=0, kicked=0, warn_cnt=0.
  - i_start in the same cycle is ignored.
- Restart after i_stop requires a new i_start. o_wd_en is low for at least one cycle, so the timer sees a fresh rising edge and reloads.
- Timing with the team timer (load T on enable edge, count to 0, registered irq):
  - o_wd_en rising in cycle e gives i_wd_irq high in cycle e+T+2.
  - o_wd_clear in cycle c gives cnt=T in c+1 and irq low from c+1.
- Async reset mid-operation returns everything to reset values immediately.
- warn_cnt width is clog2(WARN_LIMIT+1); it saturates and never wraps.

Decomposition:
- Package wdt_pkg:
  - state enum wdt_state_e {IDLE, RUN, WARN, FATAL} with 2-bit encoding matching o_state.
  - Localparam WARN_CNT_W helper.
- Sub-module kick_tracker:
  - N-bit accumulate and clear register.
  - Outputs round_complete and missing vector.
- Controller FSM, escalation counter and timer-drive registers stay in wdt_kick_ctrl.

Test Plan:
All scenarios pair the controller with the team watchdog_timer, N=4, WARN_LIMIT=2, T=10.
- Healthy run: mask=4'b1011, all three clients kick every 6 cycles -> o_wd_clear pulses once per round, i_wd_irq never rises, o_warn_irq stays 0, o_state=1.
- Single expiry: o_wd_en rises cycle 0, only client 0 kicks -> i_wd_irq cycle 12, o_warn_irq=1 and o_missing=4'b1010 cycle 13, o_state=2; a full kick round then returns RUN with o_warn_irq=0.
- Escalation: no kicks after start -> warning at first expiry, second expiry gives o_state=3, o_reset_req=1, o_wd_en=0; later kicks change nothing.
- Race: final missing kick lands in the same cycle i_wd_irq is first evaluated -> o_wd_clear pulse, no warning, o_state stays RUN.
- Stop/restart: i_stop in FATAL -> IDLE, all outputs 0 next cycle; i_start with T=5 -> irq observed 7 cycles after o_wd_en rises.
- Illegal start and reset: i_start with mask=0 or timeout=0 -> stays IDLE; async reset asserted mid-WARN -> all outputs 0 immediately.
